// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART program loader: FSM encodings,
// UART frame shape and default timing.
package imem_uart_loader_pkg;

    typedef enum logic [1:0] {
        ST_LEN  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_STOP_BITS       = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 651;
    localparam int DEFAULT_MEM_WORDS    = 4096;

    // Status outputs implied by a state, packed as {busy, done, error, core_rst_n}
    function automatic logic [3:0] state_flags(input state_t s);
        logic [3:0] f;
        case (s)
            ST_LEN:  f = 4'b1000;
            ST_DATA: f = 4'b1000;
            ST_DONE: f = 4'b0101;
            ST_ERR:  f = 4'b0010;
            default: f = 4'b0010;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection,
// centre sampling, one-cycle rx_valid / rx_ferr pulses.
module imem_uart_loader_uart_rx
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic [1:0]       sync_r;
    logic             prev_r;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_r;
    logic [7:0]       shift_r;
    logic             rx_valid_r;
    logic             rx_ferr_r;
    logic [7:0]       rx_byte_r;
    logic             rx_s;

    assign rx_s     = sync_r[1];
    assign rx_valid = rx_valid_r;
    assign rx_ferr  = rx_ferr_r;
    assign rx_byte  = rx_byte_r;

    // Synchronizer, edge detector, bit timer and frame sequencer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r     <= 2'b11;
            prev_r     <= 1'b1;
            rx_state_r <= RX_IDLE;
            cnt_r      <= '0;
            bit_r      <= 3'd0;
            shift_r    <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            rx_byte_r  <= 8'h00;
        end else begin
            sync_r     <= {sync_r[0], rx};
            prev_r     <= rx_s;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    cnt_r <= '0;
                    if (prev_r && !rx_s) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r      <= '0;
                        bit_r      <= 3'd0;
                        // a start bit that is high again at mid-bit was a glitch
                        rx_state_r <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {rx_s, shift_r[7:1]};
                        if (bit_r == LAST_BIT) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r      <= '0;
                        rx_state_r <= RX_IDLE;
                        if (rx_s) begin
                            rx_valid_r <= 1'b1;
                            rx_byte_r  <= shift_r;
                        end else begin
                            rx_ferr_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a length-prefixed little-endian word image from UART into BRAM
// port A while holding the core in reset; releases the core when complete.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MEM_WORDS    = DEFAULT_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        load_req,
    output logic [3:0]  wea,
    output logic [31:0] addra,
    output logic [31:0] dia,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [12:0] words_loaded
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    logic        rx_valid_s;
    logic        rx_ferr_s;
    logic [7:0]  rx_byte_s;
    logic        accept_s;
    logic        last_byte_s;
    logic        reload_s;
    logic [31:0] full_word_s;

    state_t      state_r;
    logic [1:0]  byte_idx_r;
    logic [23:0] asm_r;
    logic [31:0] count_r;
    logic [12:0] k_r;
    logic [12:0] words_r;
    logic [3:0]  wea_r;
    logic [31:0] addra_r;
    logic [31:0] dia_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic        core_rst_n_r;

    imem_uart_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_valid (rx_valid_s),
        .rx_byte  (rx_byte_s),
        .rx_ferr  (rx_ferr_s)
    );

    // Bytes only count while collecting; DONE/ERR discard them
    assign accept_s    = rx_valid_s && ((state_r == ST_LEN) || (state_r == ST_DATA));
    assign last_byte_s = accept_s && (byte_idx_r == 2'd3);
    assign reload_s    = load_req && ((state_r == ST_DONE) || (state_r == ST_ERR));
    assign full_word_s = {rx_byte_s, asm_r};

    assign wea          = wea_r;
    assign addra        = addra_r;
    assign dia          = dia_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign core_rst_n   = core_rst_n_r;
    assign words_loaded = words_r;

    // Little-endian byte assembly into the lower three bytes of a word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_r <= 2'd0;
            asm_r      <= 24'h000000;
        end else if (reload_s) begin
            byte_idx_r <= 2'd0;
            asm_r      <= 24'h000000;
        end else if (accept_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
                2'd0:    asm_r[7:0]   <= rx_byte_s;
                2'd1:    asm_r[15:8]  <= rx_byte_s;
                2'd2:    asm_r[23:16] <= rx_byte_s;
                default: asm_r        <= asm_r;
            endcase
        end else begin
            byte_idx_r <= byte_idx_r;
        end
    end

    // Loader FSM with BRAM write port and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_LEN;
            count_r      <= 32'd0;
            k_r          <= 13'd0;
            words_r      <= 13'd0;
            wea_r        <= 4'b0000;
            addra_r      <= 32'd0;
            dia_r        <= 32'd0;
            {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_LEN);
        end else begin
            wea_r <= 4'b0000;
            case (state_r)
                ST_LEN: begin
                    if (rx_ferr_s) begin
                        state_r <= ST_ERR;
                        {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_ERR);
                    end else if (last_byte_s) begin
                        count_r <= full_word_s;
                        k_r     <= 13'd0;
                        if (full_word_s == 32'd0) begin
                            state_r <= ST_DONE;
                            {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_DONE);
                        end else if (full_word_s > MEM_WORDS_W) begin
                            state_r <= ST_ERR;
                            {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_ERR);
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_LEN;
                    end
                end
                ST_DATA: begin
                    if (wea_r != 4'b0000) begin
                        // write cycle just issued: advance, finish after the last word
                        k_r     <= k_r + 13'd1;
                        words_r <= words_r + 13'd1;
                        if ({19'd0, k_r} == count_r - 32'd1) begin
                            state_r <= ST_DONE;
                            {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_DONE);
                        end
                    end else if (rx_ferr_s) begin
                        state_r <= ST_ERR;
                        {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_ERR);
                    end else if (last_byte_s) begin
                        wea_r   <= 4'b1111;
                        addra_r <= {17'd0, k_r, 2'b00};
                        dia_r   <= full_word_s;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (load_req) begin
                        state_r <= ST_LEN;
                        count_r <= 32'd0;
                        k_r     <= 13'd0;
                        words_r <= 13'd0;
                        {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_LEN);
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_ERR;
                    {busy_r, done_r, error_r, core_rst_n_r} <= state_flags(ST_ERR);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serialises UART frames, keeps a
// queue of expected BRAM writes and a words_loaded model checked every cycle.
module tb_imem_uart_loader;

    localparam int CPB = 8;
    localparam int MW  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        load_req = 1'b0;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dia;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_loaded;

    always #5 clk = ~clk;

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_WORDS   (MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .load_req     (load_req),
        .wea          (wea),
        .addra        (addra),
        .dia          (dia),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int  vectors = 0;
    int  miscompares = 0;
    wr_t exp_q[$];
    wr_t wr_log[$];
    int  wl_exp = 0;
    bit  model_on = 1'b0;
    bit  prev_wr = 1'b0;
    bit  lr_eff = 1'b0;
    bit  prev_done = 1'b0;
    int  cyc = 0;
    int  rxv_count = 0;
    int  last_rxv_cyc = 0;
    int  last_wr_cyc = 0;
    int  done_rise_cyc = 0;
    bit  stop_bench = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the write queue and words_loaded model
    initial begin
        while (!stop_bench) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut.u_rx.rx_valid === 1'b1) begin
                rxv_count++;
                last_rxv_cyc = cyc;
            end
            if (!rst_n) begin
                model_on = 1'b1;
                wl_exp   = 0;
            end else if (load_req && lr_eff) begin
                wl_exp = 0;
            end else if (prev_wr) begin
                wl_exp++;
            end
            prev_wr = 1'b0;
            if (model_on) begin
                check("words_loaded", 64'(words_loaded), 64'(wl_exp));
                check("status_onehot", 64'($countones({busy, done, error})), 64'(1));
                check("core_rst_n_vs_done", 64'(core_rst_n), 64'(done));
                if (done && !prev_done) done_rise_cyc = cyc;
                prev_done = done;
                if (wea !== 4'b0000) begin
                    check("wea_value", 64'(wea), 64'(4'hF));
                    check("write_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("write_addr", 64'(addra), 64'(e.addr));
                        check("write_data", 64'(dia), 64'(e.data));
                    end
                    wr_log.push_back('{addr: addra, data: dia});
                    last_wr_cyc = cyc;
                    prev_wr     = 1'b1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Sends w little-endian; when exp_wr, queues the write before the last byte
    task automatic send_word(input logic [31:0] w, input bit exp_wr, input logic [31:0] addr);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[23:16], 1'b1);
        if (exp_wr) exp_q.push_back('{addr: addr, data: w});
        send_byte(w[31:24], 1'b1);
    endtask

    task automatic pulse_load_req(input bit eff);
        @(negedge clk);
        load_req = 1'b1;
        lr_eff   = eff;
        @(negedge clk);
        load_req = 1'b0;
        lr_eff   = 1'b0;
    endtask

    task automatic wait_flag(input string name, input bit want_err);
        for (int i = 0; i < 40 * CPB; i++) begin
            if ((want_err ? error : done) === 1'b1) break;
            @(negedge clk);
        end
        check(name, 64'(want_err ? error : done), 64'(1));
    endtask

    initial begin
        int rxv0;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wea", 64'(wea), 64'(0));
        check("rst_addra", 64'(addra), 64'(0));
        check("rst_dia", 64'(dia), 64'(0));
        check("rst_core_rst_n", 64'(core_rst_n), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One-cycle glitch while idle
        rxv0 = rxv_count;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_byte", 64'(rxv_count), 64'(rxv0));
        check("glitch_busy", 64'(busy), 64'(1));

        // Two-word image, with an ignored load_req mid-DATA
        wr_log.delete();
        send_word(32'd2, 1'b0, 32'd0);
        send_word(32'h00A00513, 1'b1, 32'd0);
        pulse_load_req(1'b0);
        send_word(32'h00100593, 1'b1, 32'd4);
        wait_flag("img2_done", 1'b0);
        check("img2_nwrites", 64'(wr_log.size()), 64'(2));
        if (wr_log.size() == 2) begin
            check("img2_w0_addr", 64'(wr_log[0].addr), 64'(32'h0));
            check("img2_w0_data", 64'(wr_log[0].data), 64'(32'h00A00513));
            check("img2_w1_addr", 64'(wr_log[1].addr), 64'(32'h4));
            check("img2_w1_data", 64'(wr_log[1].data), 64'(32'h00100593));
        end
        check("img2_release_lat", 64'(done_rise_cyc - last_wr_cyc), 64'(1));
        check("img2_words", 64'(words_loaded), 64'(2));
        check("img2_core_rst_n", 64'(core_rst_n), 64'(1));
        check("img2_queue_empty", 64'(exp_q.size()), 64'(0));

        // Reload with N=0
        pulse_load_req(1'b1);
        check("reload_words", 64'(words_loaded), 64'(0));
        check("reload_core_rst_n", 64'(core_rst_n), 64'(0));
        check("reload_busy", 64'(busy), 64'(1));
        wr_log.delete();
        send_word(32'd0, 1'b0, 32'd0);
        wait_flag("n0_done", 1'b0);
        check("n0_latency_ok", 64'((done_rise_cyc - last_rxv_cyc) <= 2), 64'(1));
        check("n0_core_rst_n", 64'(core_rst_n), 64'(1));
        check("n0_nwrites", 64'(wr_log.size()), 64'(0));

        // Oversized N, then recovery with a one-word image
        pulse_load_req(1'b1);
        wr_log.delete();
        send_word(32'd4097, 1'b0, 32'd0);
        wait_flag("big_error", 1'b1);
        check("big_core_rst_n", 64'(core_rst_n), 64'(0));
        check("big_nwrites", 64'(wr_log.size()), 64'(0));
        pulse_load_req(1'b1);
        send_word(32'd1, 1'b0, 32'd0);
        send_word(32'hDEADBEEF, 1'b1, 32'd0);
        wait_flag("n1_done", 1'b0);
        check("n1_nwrites", 64'(wr_log.size()), 64'(1));
        if (wr_log.size() == 1) begin
            check("n1_addr", 64'(wr_log[0].addr), 64'(32'h0));
            check("n1_data", 64'(wr_log[0].data), 64'(32'hDEADBEEF));
        end
        check("n1_words", 64'(words_loaded), 64'(1));

        // Framing error on the 2nd byte of word 0; later bytes ignored
        pulse_load_req(1'b1);
        wr_log.delete();
        send_word(32'd2, 1'b0, 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        wait_flag("ferr_error", 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_word(32'h55667788, 1'b0, 32'd4);
        check("ferr_still_error", 64'(error), 64'(1));
        check("ferr_nwrites", 64'(wr_log.size()), 64'(0));
        check("ferr_words", 64'(words_loaded), 64'(0));
        check("ferr_core_rst_n", 64'(core_rst_n), 64'(0));

        // Reset after 5 of 8 data bytes, then a full resend
        pulse_load_req(1'b1);
        send_word(32'd2, 1'b0, 32'd0);
        send_word(32'hA1B2C3D4, 1'b1, 32'd0);
        send_byte(8'h0C, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_wea", 64'(wea), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(1));
        check("mid_rst_words", 64'(words_loaded), 64'(0));
        check("mid_rst_core_rst_n", 64'(core_rst_n), 64'(0));
        wr_log.delete();
        repeat (2) @(negedge clk);
        send_word(32'd2, 1'b0, 32'd0);
        send_word(32'hA1B2C3D4, 1'b1, 32'd0);
        send_word(32'h0F0E0D0C, 1'b1, 32'd4);
        wait_flag("resend_done", 1'b0);
        check("resend_nwrites", 64'(wr_log.size()), 64'(2));
        if (wr_log.size() == 2) begin
            check("resend_w1_addr", 64'(wr_log[1].addr), 64'(32'h4));
            check("resend_w1_data", 64'(wr_log[1].data), 64'(32'h0F0E0D0C));
        end
        check("resend_words", 64'(words_loaded), 64'(2));
        check("resend_queue_empty", 64'(exp_q.size()), 64'(0));

        repeat (4) @(negedge clk);
        stop_bench = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
Writes a program image into the BRAM instruction port (port A) from a UART byte stream while holding the pipelined core in reset. The core only reads port A. This block owns port A's write side (wea/addra/dia) during load. When the image is complete, it releases the core by deasserting core reset. It sits beside the BRAM at the top level and muxes port A with the core fetch address.

Parameters:
CLKS_PER_BIT, 651, clock cycles per UART bit (75 MHz / 115200 baud); legal range >= 4.
MEM_WORDS, 4096, capacity of the instruction region in 32-bit words; the largest legal word count.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
rx  input  1  asynchronous UART serial line, 8N1, idle high
load_req  input  1  single-cycle pulse; requests a re-load from DONE or ERR
wea  output  4  BRAM port A byte write enables
addra  output  32  BRAM port A byte address
dia  output  32  BRAM port A write data
core_rst_n  output  1  active-low reset to the core; 0 while loading
busy  output  1  high in LEN and DATA states
done  output  1  high in DONE state
error  output  1  high in ERR state
words_loaded  output  13  number of words written in the current load

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LEN; wea=0, addra=0, dia=0, core_rst_n=0, busy=1, done=0, error=0, words_loaded=0.
  - The UART receiver returns to idle.
  - All internal counters and the byte assembly register clear.
- Reset mid-load abandons the load. Words already written remain in BRAM; there is no rollback.
- UART receive:
  - rx passes through a 2-flop synchronizer.
  - A falling edge in idle starts a bit timer. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the event is a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB-first, one every CLKS_PER_BIT cycles, at bit centre.
  - The stop bit is sampled at its centre. rx_valid pulses for 1 cycle with rx_byte. A stop bit of 0 pulses rx_ferr instead.
- Byte assembly: a 2-bit byte index. Bytes are little-endian: the 1st byte goes to [7:0] and the 4th to [31:24].
- State machine LEN: collects 4 bytes as the word count N.
  - N=0: go to DONE with no writes.
  - N>MEM_WORDS: go to ERR.
  - Otherwise go to DATA with word index k=0.
- State machine DATA: on the 4th byte of each word, the next cycle drives addra=k*4, dia=word, wea=4'b1111 for exactly one cycle. Then k and words_loaded increment.
  - After the write with k=N-1, go to DONE in the following cycle.
- State machine DONE: core_rst_n=1 from the first DONE cycle. A load_req pulse moves to LEN in the next cycle, with core_rst_n=0 and words_loaded=0.
- State machine ERR: entered on rx_ferr in LEN or DATA, or on an oversized N.
  - core_rst_n stays 0, and no further writes occur.
  - Leaving ERR requires a load_req pulse (go to LEN) or rst_n.
- load_req in LEN or DATA is ignored.
- When wea=0, addra and dia hold their last values. Top level muxes addra to the core's fetch PC when core_rst_n=1.
- Bytes arriving in DONE or ERR are discarded.
- rx_valid and load_req in the same cycle in DONE: load_req wins, and that byte is discarded.
- Widths:
  - The word count register is 32 bits; the comparison against MEM_WORDS is done at full width.
  - k is 13 bits; addra = {17'b0, k, 2'b00}.
  - words_loaded saturates are unnecessary, since MEM_WORDS <= 8191 is required.

Decomposition:
- Shared package: state encoding (LEN, DATA, DONE, ERR); UART constants (data bits=8, stop bits=1); the default CLKS_PER_BIT.
- One sub-module, uart_rx: synchronizer, bit timer, shift register, rx_valid/rx_byte/rx_ferr outputs.
- imem_uart_loader holds the FSM, byte assembly and BRAM write port.

Test Plan:
- Send N=2 (bytes 02 00 00 00), then 13 05 A0 00 and 93 05 10 00 -> wea=F at addra=0 with dia=00A00513, then at addra=4 with dia=001005 93 (0x00100593); core_rst_n rises 1 cycle after the second write; words_loaded=2.
- Send N=0 -> no wea pulse; done=1 and core_rst_n=1 within 2 cycles of the 4th header byte's rx_valid.
- Send N=4097 (01 10 00 00) with MEM_WORDS=4096 -> error=1, core_rst_n=0, no writes; then load_req plus a valid N=1 image -> a single write at addr 0, then done=1.
- Corrupt the stop bit (0) on the 2nd byte of word 0 -> error=1, no write for that word; later bytes ignored.
- Assert rst_n=0 for 1 cycle after 5 of 8 data bytes -> wea=0, state LEN, words_loaded=0; a full resend of the image loads correctly.
- A 1-cycle low glitch on rx while idle -> no rx_valid, no state change; load_req pulsed during DATA -> ignored, and the load completes normally.
